// File: rtl/seq_muldiv_ctrl.sv
// seq_muldiv_ctrl: sequential unsigned multiply / divide controller.
// One WIDTH+1-bit adder/subtractor is shared by shift-add multiply and
// restoring divide. Each operation runs one iteration per clock behind a
// valid/ready handshake on both sides.
module seq_muldiv_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo,
  output logic             div_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state, next_state;

  logic [CW-1:0]    cnt;
  logic             op_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] acc_p;
  logic [WIDTH-1:0] acc_m;

  logic             accept;
  logic             div_by_zero_req;
  logic             last_iter;

  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   add_a;
  logic [WIDTH:0]   add_b;
  logic             add_cin;
  logic [WIDTH:0]   add_sum;
  logic [WIDTH-1:0] p_next;
  logic [WIDTH-1:0] m_next;

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and handshake outputs; only IDLE accepts, only DONE presents.
  always_comb begin
    next_state      = state;
    in_ready        = 1'b0;
    out_valid       = 1'b0;
    accept          = 1'b0;
    div_by_zero_req = op && (b == '0);
    last_iter       = (cnt == LAST_ITER);
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept     = 1'b1;
          next_state = div_by_zero_req ? DONE : RUN;
        end
      end
      RUN: begin
        if (last_iter) begin
          next_state = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Shared adder and one iteration of either algorithm. Multiply adds the
  // multiplicand into P (carry kept in bit WIDTH) then shifts {c,P,M} right;
  // divide shifts {R,Q} left and subtracts the divisor via ~b + 1, keeping
  // the difference only when its sign bit is clear.
  always_comb begin
    div_shift = {acc_p, acc_m[WIDTH-1]};
    add_a     = {1'b0, acc_p};
    add_b     = '0;
    add_cin   = 1'b0;
    if (op_r) begin
      add_a   = div_shift;
      add_b   = ~{1'b0, b_r};
      add_cin = 1'b1;
    end else if (acc_m[0]) begin
      add_b = {1'b0, a_r};
    end
    add_sum = add_a + add_b + {{WIDTH{1'b0}}, add_cin};

    p_next = add_sum[WIDTH:1];
    m_next = {add_sum[0], acc_m[WIDTH-1:1]};
    if (op_r) begin
      if (!add_sum[WIDTH]) begin
        p_next = add_sum[WIDTH-1:0];
        m_next = {acc_m[WIDTH-2:0], 1'b1};
      end else begin
        p_next = div_shift[WIDTH-1:0];
        m_next = {acc_m[WIDTH-2:0], 1'b0};
      end
    end
  end

  // Operand capture, iteration registers and result registers. Results
  // change only on the final iteration or a divide-by-zero accept, so they
  // stay stable for the whole time DONE waits on the consumer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      op_r     <= 1'b0;
      a_r      <= '0;
      b_r      <= '0;
      acc_p    <= '0;
      acc_m    <= '0;
      res_hi   <= '0;
      res_lo   <= '0;
      div_zero <= 1'b0;
    end else if (accept) begin
      op_r  <= op;
      a_r   <= a;
      b_r   <= b;
      acc_p <= '0;
      acc_m <= op ? a : b;
      cnt   <= '0;
      if (div_by_zero_req) begin
        res_hi   <= a;
        res_lo   <= '1;
        div_zero <= 1'b1;
      end else begin
        div_zero <= 1'b0;
      end
    end else if (state == RUN) begin
      acc_p <= p_next;
      acc_m <= m_next;
      cnt   <= cnt + 1'b1;
      if (last_iter) begin
        res_hi <= p_next;
        res_lo <= m_next;
      end
    end
  end

endmodule

// File: tb/tb_seq_muldiv_ctrl.sv
// tb_seq_muldiv_ctrl: directed and randomized checks of seq_muldiv_ctrl
// against plain arithmetic (*, /, %) for WIDTH=16.
module tb_seq_muldiv_ctrl;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        op;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] res_hi;
  logic [15:0] res_lo;
  logic        div_zero;

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_hi;
  logic [15:0] exp_lo;
  logic        exp_dz;
  int          exp_lat;

  seq_muldiv_ctrl #(.WIDTH(16)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .op(op),
    .a(a),
    .b(b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .res_hi(res_hi),
    .res_lo(res_lo),
    .div_zero(div_zero)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Global time limit so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference results straight from integer arithmetic.
  task automatic refModel(input logic o, input logic [15:0] x, input logic [15:0] y);
    logic [31:0] prod;
    if (!o) begin
      prod    = {16'h0, x} * {16'h0, y};
      exp_hi  = prod[31:16];
      exp_lo  = prod[15:0];
      exp_dz  = 1'b0;
      exp_lat = 17;
    end else if (y == 16'h0) begin
      exp_hi  = x;
      exp_lo  = 16'hFFFF;
      exp_dz  = 1'b1;
      exp_lat = 1;
    end else begin
      exp_hi  = x % y;
      exp_lo  = x / y;
      exp_dz  = 1'b0;
      exp_lat = 17;
    end
  endtask

  // Present a request at a falling edge, wait (bounded) for the accepting
  // rising edge, then scramble the inputs so later changes are exercised.
  task automatic applyStimulus(input logic o, input logic [15:0] x, input logic [15:0] y);
    bit got;
    refModel(o, x, y);
    in_valid = 1'b1;
    op       = o;
    a        = x;
    b        = y;
    got      = 1'b0;
    for (int i = 0; i < 64 && !got; i++) begin
      if (in_ready === 1'b1) begin
        @(posedge clk);
        got = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    checkOutput("accept", 32'(got), 32'h1);
    #1;
    in_valid = 1'b0;
    op       = 1'($urandom);
    a        = 16'($urandom);
    b        = 16'($urandom);
  endtask

  // Measure latency from the accept edge, check the result, optionally hold
  // off the consumer, then retire. With keep_next the next request is
  // presented on the same cycle as out_ready.
  task automatic waitResult(input int hold, input bit keep_next, input logic n_op,
                            input logic [15:0] n_a, input logic [15:0] n_b);
    bit   seen;
    int   lat;
    logic first_ready;
    seen        = 1'b0;
    lat         = 0;
    first_ready = 1'b1;
    out_ready   = (hold == 0);
    for (int k = 1; k <= 40 && !seen; k++) begin
      @(negedge clk);
      if (k == 1) first_ready = in_ready;
      if (out_valid === 1'b1) begin
        seen = 1'b1;
        lat  = k;
      end
    end
    checkOutput("latency", 32'(lat), 32'(exp_lat));
    checkOutput("busy_in_ready", 32'(first_ready), 32'h0);
    if (seen) begin
      checkOutput("res_hi", 32'(res_hi), 32'(exp_hi));
      checkOutput("res_lo", 32'(res_lo), 32'(exp_lo));
      checkOutput("div_zero", 32'(div_zero), 32'(exp_dz));
      if (hold > 0) begin
        for (int h = 0; h < hold; h++) begin
          in_valid = 1'b1;
          op       = 1'($urandom);
          a        = 16'($urandom);
          b        = 16'($urandom);
          @(negedge clk);
        end
        checkOutput("hold_out_valid", 32'(out_valid), 32'h1);
        checkOutput("hold_in_ready", 32'(in_ready), 32'h0);
        checkOutput("hold_res_hi", 32'(res_hi), 32'(exp_hi));
        checkOutput("hold_res_lo", 32'(res_lo), 32'(exp_lo));
        checkOutput("hold_div_zero", 32'(div_zero), 32'(exp_dz));
      end
      out_ready = 1'b1;
      in_valid  = keep_next;
      op        = n_op;
      a         = n_a;
      b         = n_b;
      @(negedge clk);
      checkOutput("retire_out_valid", 32'(out_valid), 32'h0);
      checkOutput("retire_in_ready", 32'(in_ready), 32'h1);
    end
    out_ready = 1'b0;
  endtask

  initial begin
    logic        r_op;
    logic [15:0] r_a;
    logic [15:0] r_b;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    op        = 1'b0;
    a         = 16'h0;
    b         = 16'h0;

    // Reset state.
    #1;
    checkOutput("rst_out_valid", 32'(out_valid), 32'h0);
    checkOutput("rst_res_hi", 32'(res_hi), 32'h0);
    checkOutput("rst_res_lo", 32'(res_lo), 32'h0);
    checkOutput("rst_div_zero", 32'(div_zero), 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_in_ready", 32'(in_ready), 32'h1);

    // Basic multiply, then the all-ones carry path.
    applyStimulus(1'b0, 16'd3, 16'd5);
    waitResult(0, 1'b0, 1'b0, 16'h0, 16'h0);
    applyStimulus(1'b0, 16'hFFFF, 16'hFFFF);
    waitResult(0, 1'b0, 1'b0, 16'h0, 16'h0);

    // Divide with remainder and with dividend below divisor.
    applyStimulus(1'b1, 16'd100, 16'd7);
    waitResult(0, 1'b0, 1'b0, 16'h0, 16'h0);
    applyStimulus(1'b1, 16'd5, 16'd9);
    waitResult(0, 1'b0, 1'b0, 16'h0, 16'h0);

    // Divide by zero: single-cycle latency.
    applyStimulus(1'b1, 16'h04D2, 16'h0);
    waitResult(0, 1'b0, 1'b0, 16'h0, 16'h0);

    // Zero operands on multiply.
    applyStimulus(1'b0, 16'h0, 16'h1234);
    waitResult(0, 1'b0, 1'b0, 16'h0, 16'h0);
    applyStimulus(1'b0, 16'h1234, 16'h0);
    waitResult(0, 1'b0, 1'b0, 16'h0, 16'h0);

    // Backpressure for five cycles with in_valid noise.
    applyStimulus(1'b1, 16'd1000, 16'd3);
    waitResult(5, 1'b0, 1'b0, 16'h0, 16'h0);

    // Retire and new request on the same cycle.
    applyStimulus(1'b0, 16'h1234, 16'h5678);
    waitResult(2, 1'b1, 1'b1, 16'hBEEF, 16'h0012);
    applyStimulus(1'b1, 16'hBEEF, 16'h0012);
    waitResult(0, 1'b0, 1'b0, 16'h0, 16'h0);

    // Reset in the middle of a multiply.
    applyStimulus(1'b0, 16'd3, 16'd5);
    repeat (8) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("midrst_out_valid", 32'(out_valid), 32'h0);
    checkOutput("midrst_res_hi", 32'(res_hi), 32'h0);
    checkOutput("midrst_res_lo", 32'(res_lo), 32'h0);
    checkOutput("midrst_div_zero", 32'(div_zero), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("midrst_in_ready", 32'(in_ready), 32'h1);
    applyStimulus(1'b1, 16'd100, 16'd7);
    waitResult(0, 1'b0, 1'b0, 16'h0, 16'h0);

    // Randomized operations with random backpressure.
    for (int n = 0; n < 40; n++) begin
      r_op = 1'($urandom);
      r_a  = 16'($urandom);
      r_b  = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
      if ($urandom_range(0, 3) == 0) r_b = 16'($urandom_range(1, 15));
      applyStimulus(r_op, r_a, r_b);
      waitResult(int'($urandom_range(0, 3)), 1'b0, 1'b0, 16'h0, 16'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
